// File: rtl/mem_dados_resp.sv
// Data-memory responder for the multicycle core: one request at a time, LATENCY-cycle response,
// byte-laned stores and sign/zero-extended loads. Define MEM_DADOS_ERR_EN for misalign/range errors.
module mem_dados_resp #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  dbg_state
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        cap_we;
  logic [63:0] cap_addr;
  logic [1:0]  cap_size;
  logic        cap_uns;
  logic [63:0] cap_wdata;

  logic [63:0] mem [DEPTH];

  // Handshake: a request transfers on a rising clk edge where req_valid and req_ready are both 1;
  // the core holds req_* stable until then, and req_ready stays 0 until the response cycle is over.
  logic hs;
  logic go_resp;
  assign hs      = req_valid && req_ready && (state == IDLE);
  assign go_resp = reset && (((state == WAIT) && (cnt == 4'd1)) ||
                             ((state == IDLE) && hs && (LATENCY == 1)));

  // With LATENCY=1 the access happens on the handshake edge itself, so use the live request.
  logic        eff_we;
  logic [63:0] eff_addr;
  logic [1:0]  eff_size;
  logic        eff_uns;
  logic [63:0] eff_wdata;
  assign eff_we    = (state == IDLE) ? req_we       : cap_we;
  assign eff_addr  = (state == IDLE) ? req_addr     : cap_addr;
  assign eff_size  = (state == IDLE) ? req_size     : cap_size;
  assign eff_uns   = (state == IDLE) ? req_unsigned : cap_uns;
  assign eff_wdata = (state == IDLE) ? req_wdata    : cap_wdata;

  logic [2:0]    off;
  logic [AW-1:0] idx;
  logic [63:0]   rword;
  assign off   = eff_addr[2:0];
  assign idx   = eff_addr[3 +: AW];
  assign rword = mem[idx];

  logic acc_err;
`ifdef MEM_DADOS_ERR_EN
  logic misal;
  always_comb begin
    misal = 1'b0;
    case (eff_size)
      2'b01:   misal = off[0];
      2'b10:   misal = (off[1:0] != 2'b00);
      2'b11:   misal = (off != 3'b000);
      default: misal = 1'b0;
    endcase
  end
  assign acc_err = misal || (eff_addr[63:3+AW] != '0);
`else
  logic unused_hi;
  assign unused_hi = ^eff_addr[63:3+AW];
  assign acc_err   = 1'b0;
`endif

  // Store path: lanes past byte 7 fall off the top of the shift and are dropped.
  logic [7:0]  size_mask;
  logic [15:0] be_wide;
  logic [7:0]  be;
  logic [63:0] wsh;
  logic [63:0] merged;
  always_comb begin
    size_mask = 8'hFF;
    case (eff_size)
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
    be_wide = {8'h00, size_mask} << off;
    be      = be_wide[7:0];
    wsh     = eff_wdata << {off, 3'b000};
    merged  = rword;
    for (int b = 0; b < 8; b++) begin
      if (be[b]) merged[8*b +: 8] = wsh[8*b +: 8];
    end
  end

  // Load path: bytes beyond the word read as zero before extension.
  logic [63:0] rsh;
  logic [63:0] load_val;
  logic [63:0] rdata_next;
  always_comb begin
    rsh      = rword >> {off, 3'b000};
    load_val = rsh;
    case (eff_size)
      2'b00:   load_val = eff_uns ? {56'd0, rsh[7:0]}  : {{56{rsh[7]}},  rsh[7:0]};
      2'b01:   load_val = eff_uns ? {48'd0, rsh[15:0]} : {{48{rsh[15]}}, rsh[15:0]};
      2'b10:   load_val = eff_uns ? {32'd0, rsh[31:0]} : {{32{rsh[31]}}, rsh[31:0]};
      default: load_val = rsh;
    endcase
    rdata_next = (eff_we || acc_err) ? 64'd0 : load_val;
  end

  always_ff @(posedge clk) begin
    if (go_resp && eff_we && !acc_err) mem[idx] <= merged;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 64'd0;
      resp_err   <= 1'b0;
      cap_we     <= 1'b0;
      cap_addr   <= 64'd0;
      cap_size   <= 2'b00;
      cap_uns    <= 1'b0;
      cap_wdata  <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            cap_we    <= req_we;
            cap_addr  <= req_addr;
            cap_size  <= req_size;
            cap_uns   <= req_unsigned;
            cap_wdata <= req_wdata;
            cnt       <= CNT_INIT;
            req_ready <= 1'b0;
            if (LATENCY == 1) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= rdata_next;
              resp_err   <= acc_err;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= rdata_next;
            resp_err   <= acc_err;
          end
        end
        RESP: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule
